// File: rtl/branch_resolve_controller.sv
// Branch resolve controller: keeps an in-order queue of in-flight branch
// predictions between IF and EX, checks each one against the resolved outcome,
// drives a registered predictor update, and on a mispredict flushes, redirects
// fetch and holds new pushes off for a short recovery window.
module branch_resolve_controller #(
   parameter int DEPTH          = 4,
   parameter int RECOVER_CYCLES = 2,
   parameter int CNT_BITS       = 16
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       if_valid,
   input  logic [31:0]                if_pc,
   input  logic                       if_pred_taken,
   input  logic [31:0]                if_pred_target,
   input  logic                       if_target_valid,
   output logic                       push_ready,
   input  logic                       ex_valid,
   input  logic [31:0]                ex_pc,
   input  logic                       ex_taken,
   input  logic [31:0]                ex_target,
   output logic                       flush,
   output logic [31:0]                redirect_pc,
   output logic                       upd_enable,
   output logic [31:0]                upd_pc,
   output logic [31:0]                upd_target,
   output logic                       upd_taken,
   output logic [$clog2(DEPTH):0]     queue_count,
   output logic [CNT_BITS-1:0]        branch_count,
   output logic [CNT_BITS-1:0]        mispredict_count,
   output logic                       protocol_err
);

   localparam int PTR_BITS = $clog2(DEPTH);
   localparam int RC_BITS  = $clog2(RECOVER_CYCLES + 1);

   localparam logic [PTR_BITS:0]  FULL_COUNT = (PTR_BITS + 1)'(DEPTH);
   localparam logic [RC_BITS-1:0] RC_LOAD    = RC_BITS'(RECOVER_CYCLES);

   localparam logic [0:0] ST_RUN     = 1'b0;
   localparam logic [0:0] ST_RECOVER = 1'b1;

   logic [0:0]          state;
   logic [RC_BITS-1:0]  recover_cnt;

   logic [31:0]         q_pc          [DEPTH];
   logic                q_pred_taken  [DEPTH];
   logic [31:0]         q_pred_target [DEPTH];
   logic                q_target_valid[DEPTH];

   logic [PTR_BITS-1:0] rd_ptr;
   logic [PTR_BITS-1:0] wr_ptr;

   logic push_fire;
   logic pop_fire;
   logic head_present;
   logic pc_mismatch;
   logic dir_mismatch;
   logic tgt_mismatch;
   logic mispredict;
   logic err_now;

   // Push is allowed only while running and not full; never depends on a same-cycle pop.
   always_comb begin
      push_ready = (state == ST_RUN) && (queue_count < FULL_COUNT);
   end

   // Decode this cycle's push/pop and compare the head entry with the EX outcome.
   always_comb begin
      push_fire    = if_valid && push_ready;
      pop_fire     = ex_valid && (state == ST_RUN);
      head_present = (queue_count != '0);
      pc_mismatch  = q_pc[rd_ptr] != ex_pc;
      dir_mismatch = q_pred_taken[rd_ptr] != ex_taken;
      tgt_mismatch = ex_taken && (!q_target_valid[rd_ptr] || (q_pred_target[rd_ptr] != ex_target));
      mispredict   = pop_fire && head_present && (pc_mismatch || dir_mismatch || tgt_mismatch);
      err_now      = pop_fire && (!head_present || pc_mismatch);
   end

   // Prediction storage; stale slots are never read because pointers gate access.
   always_ff @(posedge clock) begin
      if (push_fire) begin
         q_pc[wr_ptr]           <= if_pc;
         q_pred_taken[wr_ptr]   <= if_pred_taken;
         q_pred_target[wr_ptr]  <= if_pred_target;
         q_target_valid[wr_ptr] <= if_target_valid;
      end
   end

   // Queue pointers and occupancy; a mispredict discards every younger entry, including a same-cycle push.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         queue_count <= '0;
      end else if (mispredict) begin
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         queue_count <= '0;
      end else begin
         if (push_fire) begin
            wr_ptr <= wr_ptr + PTR_BITS'(1);
         end
         if (pop_fire && head_present) begin
            rd_ptr <= rd_ptr + PTR_BITS'(1);
         end
         case ({push_fire, pop_fire && head_present})
            2'b10:   queue_count <= queue_count + 1'b1;
            2'b01:   queue_count <= queue_count - 1'b1;
            default: queue_count <= queue_count;
         endcase
      end
   end

   // Recovery FSM: the flush cycle counts as the first recovery cycle.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state       <= ST_RUN;
         recover_cnt <= '0;
      end else begin
         case (state)
            ST_RUN: begin
               if (mispredict) begin
                  state       <= ST_RECOVER;
                  recover_cnt <= RC_LOAD;
               end
            end
            ST_RECOVER: begin
               recover_cnt <= recover_cnt - 1'b1;
               if (recover_cnt <= RC_BITS'(1)) begin
                  state <= ST_RUN;
               end
            end
            default: begin
               state       <= ST_RUN;
               recover_cnt <= '0;
            end
         endcase
      end
   end

   // Registered predictor update, flush/redirect, statistics and sticky error.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         flush            <= 1'b0;
         redirect_pc      <= '0;
         upd_enable       <= 1'b0;
         upd_pc           <= '0;
         upd_target       <= '0;
         upd_taken        <= 1'b0;
         branch_count     <= '0;
         mispredict_count <= '0;
         protocol_err     <= 1'b0;
      end else begin
         flush      <= mispredict;
         upd_enable <= pop_fire;
         if (pop_fire) begin
            upd_pc       <= ex_pc;
            upd_target   <= ex_target;
            upd_taken    <= ex_taken;
            branch_count <= branch_count + 1'b1;
         end
         if (mispredict) begin
            redirect_pc      <= ex_taken ? ex_target : (ex_pc + 32'd4);
            mispredict_count <= mispredict_count + 1'b1;
         end
         if (err_now) begin
            protocol_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_branch_resolve_controller.sv
// Self-checking bench for branch_resolve_controller: a queue-level reference
// model predicts each registered response, a monitor compares it when the DUT
// presents an update.
module tb_branch_resolve_controller;

   localparam int DEPTH          = 4;
   localparam int RECOVER_CYCLES = 2;
   localparam int CNT_BITS       = 16;

   logic                  clock;
   logic                  reset;
   logic                  if_valid;
   logic [31:0]           if_pc;
   logic                  if_pred_taken;
   logic [31:0]           if_pred_target;
   logic                  if_target_valid;
   logic                  push_ready;
   logic                  ex_valid;
   logic [31:0]           ex_pc;
   logic                  ex_taken;
   logic [31:0]           ex_target;
   logic                  flush;
   logic [31:0]           redirect_pc;
   logic                  upd_enable;
   logic [31:0]           upd_pc;
   logic [31:0]           upd_target;
   logic                  upd_taken;
   logic [$clog2(DEPTH):0] queue_count;
   logic [CNT_BITS-1:0]   branch_count;
   logic [CNT_BITS-1:0]   mispredict_count;
   logic                  protocol_err;

   typedef struct {
      logic [31:0] pc;
      logic        taken;
      logic [31:0] target;
      logic        tv;
   } pred_t;

   typedef struct {
      logic [31:0]         pc;
      logic [31:0]         target;
      logic                taken;
      logic                flush;
      logic [31:0]         redirect;
      logic [CNT_BITS-1:0] bcnt;
      logic [CNT_BITS-1:0] mcnt;
   } exp_t;

   pred_t               mq[$];
   exp_t                exp_q[$];
   int                  m_left;
   logic                m_err;
   logic [CNT_BITS-1:0] m_bcnt;
   logic [CNT_BITS-1:0] m_mcnt;

   int checks;
   int failures;

   branch_resolve_controller #(
      .DEPTH(DEPTH),
      .RECOVER_CYCLES(RECOVER_CYCLES),
      .CNT_BITS(CNT_BITS)
   ) dut (
      .clock(clock),
      .reset(reset),
      .if_valid(if_valid),
      .if_pc(if_pc),
      .if_pred_taken(if_pred_taken),
      .if_pred_target(if_pred_target),
      .if_target_valid(if_target_valid),
      .push_ready(push_ready),
      .ex_valid(ex_valid),
      .ex_pc(ex_pc),
      .ex_taken(ex_taken),
      .ex_target(ex_target),
      .flush(flush),
      .redirect_pc(redirect_pc),
      .upd_enable(upd_enable),
      .upd_pc(upd_pc),
      .upd_target(upd_target),
      .upd_taken(upd_taken),
      .queue_count(queue_count),
      .branch_count(branch_count),
      .mispredict_count(mispredict_count),
      .protocol_err(protocol_err)
   );

   // Free-running 10 ns clock.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Hard time limit so the bench can never hang.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   // Drive one cycle of inputs at the falling edge and advance the reference model.
   task automatic apply_stimulus(input logic iv, input logic [31:0] ipc, input logic ipt,
                                 input logic [31:0] itgt, input logic itv,
                                 input logic ev, input logic [31:0] epc, input logic et,
                                 input logic [31:0] etgt);
      logic  exp_ready;
      logic  misp;
      pred_t h;
      exp_t  e;
      @(negedge clock);
      exp_ready = (m_left == 0) && (mq.size() < DEPTH);
      check_output("push_ready", 32'(push_ready), 32'(exp_ready));
      check_output("queue_count", 32'(queue_count), 32'(mq.size()));
      check_output("protocol_err", 32'(protocol_err), 32'(m_err));
      if_valid        = iv;
      if_pc           = ipc;
      if_pred_taken   = ipt;
      if_pred_target  = itgt;
      if_target_valid = itv;
      ex_valid        = ev;
      ex_pc           = epc;
      ex_taken        = et;
      ex_target       = etgt;
      if (m_left > 0) begin
         m_left--;
      end else begin
         misp = 1'b0;
         if (ev) begin
            m_bcnt = m_bcnt + 1'b1;
            if (mq.size() == 0) begin
               m_err = 1'b1;
            end else begin
               h = mq.pop_front();
               misp = (h.taken != et) || (et && (!h.tv || h.target != etgt)) || (h.pc != epc);
               if (h.pc != epc) m_err = 1'b1;
            end
            e.pc       = epc;
            e.target   = etgt;
            e.taken    = et;
            e.flush    = misp;
            e.redirect = et ? etgt : epc + 32'd4;
            if (misp) begin
               m_mcnt = m_mcnt + 1'b1;
               mq.delete();
               m_left = RECOVER_CYCLES;
            end
            e.bcnt = m_bcnt;
            e.mcnt = m_mcnt;
            exp_q.push_back(e);
         end
         if (iv && exp_ready && !misp) begin
            h.pc     = ipc;
            h.taken  = ipt;
            h.target = itgt;
            h.tv     = itv;
            mq.push_back(h);
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      end
   endtask

   task automatic push_only(input logic [31:0] pc, input logic pt, input logic [31:0] tgt, input logic tv);
      apply_stimulus(1'b1, pc, pt, tgt, tv, 1'b0, 32'h0, 1'b0, 32'h0);
   endtask

   task automatic pop_only(input logic [31:0] pc, input logic et, input logic [31:0] tgt);
      apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, pc, et, tgt);
   endtask

   // Asynchronous reset away from the clock edge, then check every output is cleared.
   task automatic reset_dut();
      @(negedge clock);
      if_valid = 1'b0;
      ex_valid = 1'b0;
      #3;
      reset = 1'b0;
      mq.delete();
      exp_q.delete();
      m_left = 0;
      m_err  = 1'b0;
      m_bcnt = '0;
      m_mcnt = '0;
      #1;
      check_output("rst_flush", 32'(flush), 32'h0);
      check_output("rst_upd_enable", 32'(upd_enable), 32'h0);
      check_output("rst_upd_pc", upd_pc, 32'h0);
      check_output("rst_upd_target", upd_target, 32'h0);
      check_output("rst_upd_taken", 32'(upd_taken), 32'h0);
      check_output("rst_redirect_pc", redirect_pc, 32'h0);
      check_output("rst_queue_count", 32'(queue_count), 32'h0);
      check_output("rst_branch_count", 32'(branch_count), 32'h0);
      check_output("rst_mispredict_count", 32'(mispredict_count), 32'h0);
      check_output("rst_protocol_err", 32'(protocol_err), 32'h0);
      @(negedge clock);
      reset = 1'b1;
   endtask

   // Monitor: after each rising edge, match any presented update against the scoreboard.
   always begin
      exp_t e;
      @(posedge clock);
      #1;
      if (reset) begin
         if (upd_enable) begin
            if (exp_q.size() == 0) begin
               check_output("unexpected_update", 32'(upd_enable), 32'h0);
            end else begin
               e = exp_q.pop_front();
               check_output("upd_pc", upd_pc, e.pc);
               check_output("upd_target", upd_target, e.target);
               check_output("upd_taken", 32'(upd_taken), 32'(e.taken));
               check_output("flush", 32'(flush), 32'(e.flush));
               if (e.flush) check_output("redirect_pc", redirect_pc, e.redirect);
               check_output("branch_count", 32'(branch_count), 32'(e.bcnt));
               check_output("mispredict_count", 32'(mispredict_count), 32'(e.mcnt));
            end
         end else begin
            check_output("idle_flush", 32'(flush), 32'h0);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check_output("missing_update", 32'(upd_enable), 32'h1);
            end
         end
      end
   end

   // Directed scenarios, a randomized phase, then error and reset handling.
   initial begin
      logic        iv, ev, et, ipt, itv;
      logic [31:0] ipc, itgt, epc, etgt;
      int          r;
      pred_t       h;
      checks   = 0;
      failures = 0;
      reset    = 1'b0;
      if_valid = 1'b0; if_pc = '0; if_pred_taken = 1'b0; if_pred_target = '0; if_target_valid = 1'b0;
      ex_valid = 1'b0; ex_pc = '0; ex_taken = 1'b0; ex_target = '0;
      m_left = 0; m_err = 1'b0; m_bcnt = '0; m_mcnt = '0;
      reset_dut();

      $display("[TB] correct not-taken");
      push_only(32'h100, 1'b0, 32'h0, 1'b0);
      pop_only(32'h100, 1'b0, 32'h0);
      idle(2);

      $display("[TB] direction mispredict");
      push_only(32'h200, 1'b0, 32'h0, 1'b0);
      pop_only(32'h200, 1'b1, 32'h400);
      idle(3);

      $display("[TB] target mispredict");
      push_only(32'h300, 1'b1, 32'h500, 1'b1);
      pop_only(32'h300, 1'b1, 32'h540);
      idle(3);

      $display("[TB] wrong-path cleanup");
      push_only(32'h10, 1'b0, 32'h0, 1'b0);
      push_only(32'h20, 1'b0, 32'h0, 1'b0);
      push_only(32'h30, 1'b0, 32'h0, 1'b0);
      push_only(32'h40, 1'b0, 32'h0, 1'b0);
      push_only(32'h50, 1'b0, 32'h0, 1'b0);
      pop_only(32'h10, 1'b1, 32'h80);
      pop_only(32'h20, 1'b0, 32'h0);
      pop_only(32'h20, 1'b0, 32'h0);
      idle(2);

      $display("[TB] simultaneous push with mispredict");
      push_only(32'h50, 1'b0, 32'h0, 1'b0);
      apply_stimulus(1'b1, 32'h60, 1'b0, 32'h0, 1'b0, 1'b1, 32'h50, 1'b1, 32'h90);
      idle(3);
      push_only(32'h70, 1'b0, 32'h0, 1'b0);
      pop_only(32'h70, 1'b0, 32'h0);
      idle(2);

      $display("[TB] randomized traffic");
      for (int n = 0; n < 400; n++) begin
         iv   = ($urandom_range(0, 1) == 1);
         ipc  = $urandom & 32'hFFFF_FFFC;
         ipt  = ($urandom_range(0, 1) == 1);
         itv  = ($urandom_range(0, 3) != 0);
         itgt = $urandom & 32'hFFFF_FFFC;
         ev   = 1'b0; epc = '0; et = 1'b0; etgt = '0;
         if (mq.size() != 0 && $urandom_range(0, 9) < 5) begin
            h    = mq[0];
            ev   = 1'b1;
            epc  = h.pc;
            et   = h.taken;
            etgt = h.tv ? h.target : ($urandom & 32'hFFFF_FFFC);
            r    = $urandom_range(0, 9);
            if (r == 0) begin
               et   = ~et;
               etgt = $urandom & 32'hFFFF_FFFC;
            end else if (r == 1) begin
               etgt = etgt ^ 32'h40;
            end else if (r == 2) begin
               epc = epc ^ 32'h4;
            end
         end
         apply_stimulus(iv, ipc, ipt, itgt, itv, ev, epc, et, etgt);
      end
      idle(4);
      check_output("scoreboard_drained", 32'(exp_q.size()), 32'h0);

      $display("[TB] empty-queue pop and reset mid-recover");
      reset_dut();
      pop_only(32'h123, 1'b0, 32'h0);
      idle(1);
      check_output("err_after_empty_pop", 32'(protocol_err), 32'h1);
      push_only(32'h200, 1'b0, 32'h0, 1'b0);
      pop_only(32'h200, 1'b1, 32'h400);
      reset_dut();
      idle(2);
      check_output("final_scoreboard_empty", 32'(exp_q.size()), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/branch_resolve_controller.md
Name: branch_resolve_controller

Overview:
- Sequences the two-level branch predictor between prediction (IF) and resolution (EX).
- Holds an in-order queue of in-flight predictions and compares each against the EX outcome.
- Drives a registered update port into the predictor, and raises flush/redirect on a mispredict.
- Runs a short recovery FSM that blocks new pushes while the pipeline refills.

Parameters:
DEPTH, 4, in-flight prediction queue entries (power of 2, ≥2)
RECOVER_CYCLES, 2, cycles push_ready stays low after a flush (≥1)
CNT_BITS, 16, width of statistics counters

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
if_valid  in  1  branch prediction issued this cycle; push request
if_pc  in  32  PC of predicted branch
if_pred_taken  in  1  predictor direction
if_pred_target  in  32  predictor target
if_target_valid  in  1  BTB hit
push_ready  out  1  queue accepts a push (IF stalls branch when 0)
ex_valid  in  1  branch resolved this cycle; pop request
ex_pc  in  32  PC of resolved branch
ex_taken  in  1  actual direction
ex_target  in  32  actual taken target
flush  out  1  one-cycle squash of younger instructions
redirect_pc  out  32  fetch restart PC, valid with flush
upd_enable  out  1  predictor update strobe
upd_pc  out  32  predictor update PC
upd_target  out  32  predictor update target
upd_taken  out  1  predictor update direction
queue_count  out  $clog2(DEPTH)+1  occupied entries
branch_count  out  CNT_BITS  resolved branches (wraps)
mispredict_count  out  CNT_BITS  mispredicts (wraps)
protocol_err  out  1  sticky error flag

Behaviour:
- Reset (reset=0, async):
  - queue empty, state=RUN, all counters 0, protocol_err=0.
  - flush=0, upd_enable=0, redirect_pc/upd_* = 0.
  - push_ready=1 once reset is released.
- States: RUN, RECOVER.
- Push:
  - Accepted when if_valid && push_ready.
  - Entry stores {if_pc, if_pred_taken, if_pred_target, if_target_valid} at the tail.
  - push_ready = (state==RUN) && (queue_count<DEPTH). It is not combinationally dependent on a same-cycle pop.
- Pop (RUN only):
  - ex_valid removes the head entry and compares it with the EX outcome.
  - Mispredict when any of the following holds:
    - head.pred_taken != ex_taken;
    - ex_taken && (!head.target_valid || head.pred_target != ex_target);
    - head.pc != ex_pc. This also sets protocol_err.
- Empty-queue pop: ex_valid with queue_count==0 sets protocol_err, makes no comparison and no flush, but still issues the update.
- Outputs registered, 1-cycle latency. For every accepted ex_valid in RUN, on the next cycle:
  - upd_enable=1, upd_pc=ex_pc, upd_target=ex_target, upd_taken=ex_taken.
  - branch_count increments.
- On mispredict, on the next cycle:
  - flush=1 for exactly one cycle; mispredict_count increments.
  - redirect_pc = ex_taken ? ex_target : ex_pc+4 (32-bit wrap).
  - Queue is cleared entirely (all younger entries are wrong-path).
  - state goes RUN→RECOVER.
- Simultaneous push and pop in RUN without mispredict: both take effect; queue_count unchanged.
- Simultaneous push and mispredicting pop: the push is discarded; queue_count becomes 0.
- RECOVER:
  - push_ready=0.
  - ex_valid is ignored: no update, no counters, no error.
  - An internal counter loads RECOVER_CYCLES on entry; the state returns to RUN when it expires.
  - push_ready=1 on the first RUN cycle, i.e. RECOVER_CYCLES cycles after the flush cycle.
- Counters and pointers:
  - Counters wrap at 2^CNT_BITS.
  - Queue read/write pointers wrap modulo DEPTH.
  - queue_count saturates logically at DEPTH, since pushes are blocked when full.
- protocol_err clears only on reset.
- Reset asserted mid-operation or mid-RECOVER: immediate return to reset values; no pending flush or update is emitted.

Test Plan:
- Correct not-taken:
  - Stimulus: push pc=0x100, pred_taken=0; then ex_valid, ex_pc=0x100, ex_taken=0.
  - Response: next cycle upd_enable=1, upd_taken=0, flush=0, branch_count=1, queue_count=0.
- Direction mispredict:
  - Stimulus: push pc=0x200, pred_taken=0; then ex_taken=1, ex_target=0x400.
  - Response: flush=1 for one cycle, redirect_pc=0x400, mispredict_count=1.
  - Response: push_ready=0 for 2 cycles, then 1.
- Target mispredict:
  - Stimulus: push pc=0x300, pred_taken=1, target_valid=1, pred_target=0x500; then ex_taken=1, ex_target=0x540.
  - Response: flush, redirect_pc=0x540, upd_target=0x540.
- Wrong-path cleanup:
  - Stimulus: push 4 entries (pc 0x10, 0x20, 0x30, 0x40); push_ready=0 at count 4; resolve 0x10 as taken vs predicted not-taken (ex_target=0x80).
  - Response: redirect_pc=0x80, queue_count=0.
  - Response: ex_valid during the following 2 cycles produces no upd_enable.
- Simultaneous push with mispredict:
  - Stimulus: same-cycle push of pc=0x60 and mispredicting pop.
  - Response: queue_count=0 after flush; the 0x60 entry is absent.
- Errors and reset:
  - Stimulus: ex_valid on an empty queue.
  - Response: protocol_err=1, upd_enable=1, flush=0.
  - Stimulus: then drive reset=0 asynchronously mid-RECOVER.
  - Response: all outputs and counters 0, push_ready=1 after release.
